// File: rtl/mcu0_mem_pkg.sv
// Shared types and constants for the mcu0 memory arbiter.
package mcu0_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester indices: 0 is the core bus, 1 is the debug/program loader
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

endpackage

// File: rtl/mcu0_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick. The last-served pointer lives in the parent,
// so this block is purely combinational.
module rr_arb2
  import mcu0_mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic idx,
  output logic vld
);

  // On a tie, favour whichever requester was not served last
  always_comb begin
    vld = req0 | req1;
    idx = REQ_CPU;
    if (req0 && req1) begin
      idx = ~last;
    end else if (req1) begin
      idx = REQ_DBG;
    end
  end

endmodule

// File: rtl/mcu0_mem_arbiter.sv
// Arbiter and access sequencer in front of the single mcu0 memory.
// One access at a time: grant in IDLE, wait for mready (or time out) in
// ACCESS, pulse done to the winner in RESP. All outputs are registered.
module mcu0_mem_arbiter
  import mcu0_mem_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          w0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          w1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          men,
  output logic          mw,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mready,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_t        state;
  logic          last;
  logic          win;
  logic [CW-1:0] cnt;
  logic          gnt_idx;
  logic          gnt_vld;

  rr_arb2 u_arb (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .idx  (gnt_idx),
    .vld  (gnt_vld)
  );

  // Access sequencer: grant, hold the memory bus until ready/timeout, respond
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      last   <= REQ_DBG;
      win    <= REQ_CPU;
      cnt    <= '0;
      men    <= 1'b0;
      mw     <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      busy   <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            win   <= gnt_idx;
            last  <= gnt_idx;
            men   <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ACCESS;
            if (gnt_idx == REQ_DBG) begin
              mw     <= w1;
              maddr  <= addr1;
              mwdata <= wdata1;
            end else begin
              mw     <= w0;
              maddr  <= addr0;
              mwdata <= wdata0;
            end
          end
        end
        ACCESS: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
          // Ready wins over a timeout landing on the same cycle
          if (mready || (cnt == CNT_LAST)) begin
            men   <= 1'b0;
            mw    <= 1'b0;
            state <= RESP;
            if (win == REQ_DBG) begin
              done1 <= 1'b1;
              err1  <= ~mready;
              if (mready && !mw) begin
                rdata1 <= mrdata;
              end
            end else begin
              done0 <= 1'b1;
              err0  <= ~mready;
              if (mready && !mw) begin
                rdata0 <= mrdata;
              end
            end
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu0_mem_arbiter.sv
// Bench for mcu0_mem_arbiter: directed scenarios with literal expectations,
// then random traffic, all cross-checked every cycle against a
// transaction-level model of the arbiter.
module tb_mcu0_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TIMEOUT = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, w0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          req1 = 1'b0, w1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic [DW-1:0] mrdata = '0;
  logic          mready = 1'b0;
  logic          done0, err0, done1, err1, men, mw, busy;
  logic [DW-1:0] rdata0, rdata1, mwdata;
  logic [AW-1:0] maddr;

  int checks = 0;
  int failures = 0;

  mcu0_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .w0(w0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .w1(w1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .men(men), .mw(mw), .maddr(maddr), .mwdata(mwdata),
    .mrdata(mrdata), .mready(mready), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // The model thinks in terms of "an access in flight, its age in cycles,
  // and a one-cycle response slot", updated from the inputs at each edge.
  bit            m_started = 0;
  bit            m_inflight = 0;
  bit            m_respslot = 0;
  int            m_age = 0;
  int            m_who = 0;
  int            m_last = 1;
  bit            m_wr = 0;
  bit            e_men = 0, e_mw = 0, e_busy = 0;
  logic [AW-1:0] e_maddr = '0;
  logic [DW-1:0] e_mwdata = '0;
  bit            e_done[2];
  bit            e_err[2];
  logic [DW-1:0] e_rdata[2];

  always @(posedge clock) begin
    bit r[2];
    r[0] = req0;
    r[1] = req1;
    m_started = 1;
    if (reset) begin
      m_inflight = 0; m_respslot = 0; m_last = 1;
      e_men = 0; e_mw = 0; e_busy = 0; e_maddr = '0; e_mwdata = '0;
      for (int i = 0; i < 2; i++) begin
        e_done[i] = 0; e_err[i] = 0; e_rdata[i] = '0;
      end
    end else begin
      e_done[0] = 0;
      e_done[1] = 0;
      if (m_respslot) begin
        m_respslot = 0;
        e_busy = 0;
      end else if (m_inflight) begin
        m_age++;
        if (mready || m_age == TIMEOUT) begin
          if (mready && !m_wr) e_rdata[m_who] = mrdata;
          e_err[m_who] = !mready;
          e_done[m_who] = 1;
          m_inflight = 0; m_respslot = 1;
          e_men = 0; e_mw = 0;
        end
      end else if (r[0] || r[1]) begin
        m_who = (r[0] && r[1]) ? 1 - m_last : (r[1] ? 1 : 0);
        m_last = m_who;
        m_inflight = 1; m_age = 0;
        m_wr = (m_who == 1) ? w1 : w0;
        e_maddr = (m_who == 1) ? addr1 : addr0;
        e_mwdata = (m_who == 1) ? wdata1 : wdata0;
        e_men = 1; e_mw = m_wr; e_busy = 1;
      end
    end
  end

  // Single compare process: DUT against model, every cycle, on the falling edge
  always @(negedge clock) begin
    if (m_started) begin
      chk("men", 32'(men), 32'(e_men));
      chk("mw", 32'(mw), 32'(e_mw));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done0", 32'(done0), 32'(e_done[0]));
      chk("done1", 32'(done1), 32'(e_done[1]));
      chk("rdata0", 32'(rdata0), 32'(e_rdata[0]));
      chk("rdata1", 32'(rdata1), 32'(e_rdata[1]));
      chk("done_exclusive", 32'(done0 & done1), 32'(0));
      if (e_men) begin
        chk("maddr", 32'(maddr), 32'(e_maddr));
        chk("mwdata", 32'(mwdata), 32'(e_mwdata));
      end
      if (e_done[0]) chk("err0", 32'(err0), 32'(e_err[0]));
      if (e_done[1]) chk("err1", 32'(err1), 32'(e_err[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_any_done(output int who, input int max);
    who = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done0) begin who = 0; break; end
      if (done1) begin who = 1; break; end
    end
    if (who < 0) chk("wait_done_bound", 32'(0), 32'(1));
  endtask

  task automatic upd(input logic r, input logic d, output logic nr,
                     output logic nw, output logic [AW-1:0] na, output logic [DW-1:0] nd,
                     input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    bit fresh;
    nr = r; nw = cw; na = ca; nd = cd;
    fresh = 0;
    if (!r) begin
      if ($urandom_range(0, 3) == 0) begin nr = 1; fresh = 1; end
    end else if (d) begin
      if ($urandom_range(0, 1) == 1) nr = 0;
      else fresh = 1;
    end else begin
      if ($urandom_range(0, 31) == 0) nr = 0;
      else if ($urandom_range(0, 15) == 0) fresh = 1;
    end
    if (fresh) begin
      nw = 1'($urandom_range(0, 1));
      na = AW'($urandom);
      nd = DW'($urandom);
    end
  endtask

  initial begin
    int who;
    int n;
    int stall;
    logic nr, nw;
    logic [AW-1:0] na;
    logic [DW-1:0] nd;

    // 1: reset values, then a single read
    tick(); tick();
    chk("rst_men", 32'(men), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rdata0", 32'(rdata0), 32'(0));
    reset = 0;
    req0 = 1; w0 = 0; addr0 = 12'h010;
    tick();
    chk("t1_men", 32'(men), 32'(1));
    chk("t1_maddr", 32'(maddr), 32'h010);
    chk("t1_busy", 32'(busy), 32'(1));
    mready = 1; mrdata = 16'h1234;
    tick();
    chk("t1_done0", 32'(done0), 32'(1));
    chk("t1_rdata0", 32'(rdata0), 32'h1234);
    chk("t1_err0", 32'(err0), 32'(0));
    chk("t1_men_resp", 32'(men), 32'(0));
    req0 = 0; mready = 0; mrdata = 16'h0;
    tick();
    chk("t1_done0_once", 32'(done0), 32'(0));
    chk("t1_rdata0_held", 32'(rdata0), 32'h1234);

    // 2: requester 1 write, fields changed after grant are ignored
    req1 = 1; w1 = 1; addr1 = 12'h020; wdata1 = 16'hBEEF;
    tick();
    addr1 = 12'h0FF; wdata1 = 16'h0000; w1 = 0;
    for (int i = 0; i < 2; i++) begin
      chk("t2_mw", 32'(mw), 32'(1));
      chk("t2_maddr", 32'(maddr), 32'h020);
      chk("t2_mwdata", 32'(mwdata), 32'hBEEF);
      tick();
    end
    chk("t2_mw_last", 32'(mw), 32'(1));
    mready = 1; mrdata = 16'h5555;
    tick();
    chk("t2_done1", 32'(done1), 32'(1));
    chk("t2_rdata1", 32'(rdata1), 32'h0);
    req1 = 0; mready = 0;
    tick();

    // 3: tie from reset, both keep requesting -> 0,1,0,1
    reset = 1; tick(); reset = 0;
    req0 = 1; req1 = 1; w0 = 0; w1 = 0; addr0 = 12'h111; addr1 = 12'h222; mready = 1;
    for (int k = 0; k < 4; k++) begin
      wait_any_done(who, 20);
      chk("t3_order", 32'(who), 32'(k % 2));
    end
    req0 = 0; req1 = 0; mready = 0;
    tick();

    // 4: timeout
    req0 = 1; w0 = 0; addr0 = 12'h100;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0) break;
      if (men) n++;
      tick();
    end
    chk("t4_men_cycles", 32'(n), 32'(TIMEOUT));
    chk("t4_done0", 32'(done0), 32'(1));
    chk("t4_err0", 32'(err0), 32'(1));
    chk("t4_men_resp", 32'(men), 32'(0));
    req0 = 0;
    tick();

    // 5: req dropped mid-access, mready late
    req0 = 1; w0 = 0; addr0 = 12'h055;
    tick();
    tick();
    req0 = 0;
    tick(); tick(); tick();
    mready = 1; mrdata = 16'hA5A5;
    tick();
    chk("t5_done0", 32'(done0), 32'(1));
    chk("t5_rdata0", 32'(rdata0), 32'hA5A5);
    chk("t5_err0", 32'(err0), 32'(0));
    mready = 0;
    tick();

    // 6: reset in the middle of an access
    req1 = 1; w1 = 1; addr1 = 12'h0AA; wdata1 = 16'h7777;
    tick(); tick();
    reset = 1;
    tick();
    chk("t6_men", 32'(men), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_done1", 32'(done1), 32'(0));
    reset = 0; req0 = 1; w0 = 0; addr0 = 12'h0CC;
    tick();
    chk("t6_tie_to_0", 32'(maddr), 32'h0CC);
    mready = 1; mrdata = 16'h3C3C;
    tick();
    chk("t6_done0", 32'(done0), 32'(1));
    req0 = 0; req1 = 0; mready = 0;
    tick();

    // Random traffic against the model
    stall = 0;
    for (int c = 0; c < 4000; c++) begin
      if (reset) reset = 0;
      else if ($urandom_range(0, 499) == 0) reset = 1;
      upd(req0, done0, nr, nw, na, nd, w0, addr0, wdata0);
      req0 = nr; w0 = nw; addr0 = na; wdata0 = nd;
      upd(req1, done1, nr, nw, na, nd, w1, addr1, wdata1);
      req1 = nr; w1 = nw; addr1 = na; wdata1 = nd;
      if (stall > 0) begin
        mready = 0;
        stall--;
      end else begin
        if ($urandom_range(0, 299) == 0) stall = 40;
        mready = ($urandom_range(0, 2) == 0);
      end
      mrdata = DW'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
